// File: rtl/four_to_two_encoder_module.sv
// Request-queueing 4:2 priority encoder with a valid/ready output handshake.
// Requests are held in a pending vector and presented lowest index first, one code per handshake.
module four_to_two_encoder_module (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       out_ready,
    output logic       out_a,
    output logic       out_b,
    output logic       out_valid,
    output logic [3:0] pending,
    output logic       overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] code;
    logic [3:0] req;
    logic [3:0] served;
    logic [3:0] rem;
    logic       handshake;

    function automatic logic [1:0] lowest_index(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    always_comb begin
        req       = {in3, in2, in1, in0};
        handshake = (state == VALID) && out_ready;
        served    = '0;
        if (handshake) served = 4'b0001 << code;
        rem       = pending & ~served;
    end

    // Selection uses the pre-edge pending vector, so same-edge requests wait a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            code     <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= rem | req;
            overflow <= |(req & pending & ~served);
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state <= VALID;
                        code  <= lowest_index(pending);
                    end
                end
                VALID: begin
                    if (handshake) begin
                        if (|rem) begin
                            code <= lowest_index(rem);
                        end else begin
                            state <= IDLE;
                            code  <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    code  <= '0;
                end
            endcase
        end
    end

    assign out_a     = code[0];
    assign out_b     = code[1];
    assign out_valid = (state == VALID);

endmodule

// File: doc/four_to_two_encoder_module.md
FOUR_TO_TWO_ENCODER_MODULE -- requirements
Module: four_to_two_encoder_module

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in0, in1, in2, in3  input  1 each  request lines; a 1 sampled at a rising edge posts one request for that line.
REQ-005 out_a  output  1  code bit 0 (LSB); index = {out_b,out_a}.
REQ-006 out_b  output  1  code bit 1 (MSB).
REQ-007 out_valid  output  1  out_a/out_b hold a valid code.
REQ-008 out_ready  input  1  consumer accepts the code; handshake = out_valid & out_ready at a rising edge.
REQ-009 pending  output  4  registered pending-request vector, bit i = line in_i.
REQ-010 overflow  output  1  one-cycle pulse, request lost on an already-pending line.

Function
REQ-011 Code mapping SHALL be the inverse of the team 2:4 decoder: in0->{b,a}=00, in1->01, in2->10, in3->11.
REQ-012 Pending update per edge: pending <= (pending & ~served) | req, where req = {in3,in2,in1,in0} and served = one-hot of the current code when a handshake occurs, else 0.
REQ-013 A request on the line being served in the same cycle SHALL set that bit again (re-request wins) with no overflow.
REQ-014 overflow SHALL pulse for exactly the cycle after an edge where req[i]=1, pending[i]=1 and served[i]=0, for any i; the request merges, no second service.
REQ-015 FSM states: IDLE (out_valid=0) and VALID (out_valid=1).
REQ-016 IDLE -> VALID at an edge where pending != 0: load code of the lowest-index set pending bit; requests arriving that same edge SHALL NOT be considered.
REQ-017 IDLE with pending == 0 SHALL remain IDLE.
REQ-018 VALID, no handshake: stay VALID; out_a, out_b SHALL be held stable.
REQ-019 VALID with handshake: let rem = pending & ~served; if rem != 0 load lowest-index bit of rem and stay VALID (back-to-back, one code per cycle); else go IDLE.
REQ-020 The code being presented SHALL remain set in pending until its handshake.
REQ-021 Latency: request sampled at edge N -> pending set after edge N -> out_valid=1 after edge N+1 when IDLE.
REQ-022 out_a/out_b SHALL be 0 whenever out_valid=0.
REQ-023 Priority is fixed, lowest index first; no fairness guarantee under continuous low-index requests.

Reset
REQ-024 reset_n low SHALL immediately (no clock) force state=IDLE, pending=0000, out_valid=0, out_a=0, out_b=0, overflow=0.
REQ-025 Reset asserted mid-operation SHALL discard all pending and in-flight codes; no code is emitted for pre-reset requests.
REQ-026 First request sampled at the first rising edge after reset_n rises SHALL be accepted normally.

Verification
REQ-027 in2 pulsed one cycle, out_ready=1 -> out_valid=1 with {b,a}=10 one cycle after pending=0100; next cycle out_valid=0, pending=0000.
REQ-028 in0..in3 pulsed together, out_ready=1 -> codes 00,01,10,11 on 4 consecutive cycles, then out_valid=0, pending=0000, overflow never set.
REQ-029 in1 and in3 pending, out_ready=0 for 5 cycles -> code 01 held stable 5 cycles; out_ready=1 -> 01 accepted, then 11, then IDLE.
REQ-030 in1 pulsed, then pulsed again while pending=0010 and out_ready=0 -> overflow=1 for one cycle, exactly one code 01 delivered.
REQ-031 code 00 presented, in0 pulsed on its handshake cycle -> pending bit0 stays 1, code 00 delivered twice, overflow=0.
REQ-032 reset_n driven low while out_valid=1 and pending=1010 -> outputs 0 and pending=0000 before the next clock edge; no codes after release without new requests.
